// File: rtl/case_7_mul_arb_pkg.sv
// Shared defaults and operand/product types for the round-robin multiplier sharing block.
package case_7_mul_arb_pkg;
  localparam int DEF_NREQ = 4;
  localparam int DEF_A_W  = 8;
  localparam int DEF_B_W  = 6;
  localparam int DEF_P_W  = 13;
  localparam int DEF_ID_W = $clog2(DEF_NREQ);

  typedef logic signed [DEF_A_W-1:0]  opa_t;
  typedef logic signed [DEF_B_W-1:0]  opb_t;
  typedef logic signed [DEF_P_W-1:0]  prod_t;
  typedef logic        [DEF_ID_W-1:0] id_t;
endpackage

// File: rtl/case_7_mul_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant scanning upward from ptr.
// Pointer moves one past the winner only when a grant is actually taken (adv_i).
module case_7_mul_rr_arb
  import case_7_mul_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic            ap_clk,
  input  logic            ap_rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) begin
      ptr_d = (gnt_id_o == ID_W'(NREQ-1)) ? '0 : gnt_id_o + ID_W'(1);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/case_7_mul_share_arb.sv
// One pipelined signed multiplier shared by NREQ requesters; 2-cycle accept-to-rsp, 1/cycle, stall holds whole pipe.
// Optional perf counters behind CASE_7_MUL_ARB_PERF_EN.
module case_7_mul_share_arb
  import case_7_mul_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int A_W  = DEF_A_W,
  parameter int B_W  = DEF_B_W,
  parameter int P_W  = DEF_P_W,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [NREQ-1:0]   req_vld,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [ID_W-1:0]   rsp_id,
  output logic [P_W-1:0]    rsp_p
`ifdef CASE_7_MUL_ARB_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int F_W = A_W + B_W;

  logic                  adv;
  logic                  accept;
  logic [NREQ-1:0]       gnt;
  logic [ID_W-1:0]       gnt_id;
  logic signed [A_W-1:0] a_sel;
  logic signed [B_W-1:0] b_sel;
  logic signed [F_W-1:0] full;

  logic                  s1_vld_q, s1_vld_d;
  logic signed [A_W-1:0] s1_a_q,   s1_a_d;
  logic signed [B_W-1:0] s1_b_q,   s1_b_d;
  logic [ID_W-1:0]       s1_id_q,  s1_id_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]       rsp_id_q,  rsp_id_d;
  logic [P_W-1:0]        rsp_p_q,   rsp_p_d;

  assign adv     = !rsp_vld_q || rsp_rdy;
  assign req_rdy = ap_rst ? '0 : (gnt & {NREQ{adv}});
  assign accept  = |req_rdy;

  case_7_mul_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .req_i    (req_vld),
    .adv_i    (adv),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign a_sel = req_a[int'(gnt_id)*A_W +: A_W];
  assign b_sel = req_b[int'(gnt_id)*B_W +: B_W];
  // Sign-extend both operands to full width first; P_W low bits give the wrap.
  assign full  = F_W'(s1_a_q) * F_W'(s1_b_q);

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_id_d   = s1_id_q;
    rsp_vld_d = rsp_vld_q;
    rsp_id_d  = rsp_id_q;
    rsp_p_d   = rsp_p_q;
    if (adv) begin
      s1_vld_d  = accept;
      rsp_vld_d = s1_vld_q;
      if (accept) begin
        s1_a_d  = a_sel;
        s1_b_d  = b_sel;
        s1_id_d = gnt_id;
      end
      if (s1_vld_q) begin
        rsp_p_d  = full[P_W-1:0];
        rsp_id_d = s1_id_q;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_id_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_p_q   <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_id_q   <= s1_id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_p_q   <= rsp_p_d;
    end
  end

  assign rsp_vld = rsp_vld_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_p   = rsp_p_q;

`ifdef CASE_7_MUL_ARB_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issue_d = perf_issue_q + (accept ? 32'd1 : 32'd0);
    perf_stall_d = perf_stall_q + ((rsp_vld_q && !rsp_rdy) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
